// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// The optional round-robin build is selected with BUS_ARBITER_ROUND_ROBIN_EN.
package bus_arbiter_pkg;

  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDataWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MstM1 = 1'b0;
  localparam logic MstM2 = 1'b1;

  // Master ID to grant/done bit position: bit 0 is M1, bit 1 is M2.
  function automatic logic [1:0] mst_onehot(input logic id);
    return (id == MstM2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arbiter_arb_select.sv
// Combinational master choice: one-hot select plus valid from the request pair.
// With BUS_ARBITER_ROUND_ROBIN_EN a tie goes to the master not served last.
module bus_arbiter_arb_select
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  input  logic       last_i,
`endif
  output logic [1:0] sel_o,
  output logic       valid_o
);

  always_comb begin
    sel_o = 2'b00;
    case (req_i)
      2'b01:   sel_o = 2'b01;
      2'b10:   sel_o = 2'b10;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      2'b11:   sel_o = (last_i == MstM1) ? 2'b10 : 2'b01;
`else
      2'b11:   sel_o = 2'b01;
`endif
      default: sel_o = 2'b00;
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the bus address decoder; all outputs registered.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin contention instead of fixed M1 priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_wen,
  input  logic                  m1_ren,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_grant,
  output logic                  m1_done,
  output logic                  m1_err,
  input  logic                  m2_req,
  input  logic [ADDR_WIDTH-1:0] m2_addr,
  input  logic                  m2_wen,
  input  logic                  m2_ren,
  input  logic [DATA_WIDTH-1:0] m2_wdata,
  output logic                  m2_grant,
  output logic                  m2_done,
  output logic                  m2_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [DATA_WIDTH-1:0] m_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_wen_q, bus_wen_d;
  logic                  bus_ren_q, bus_ren_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0] sel;
  logic       sel_valid;
  logic       timeout;
  logic       pick_wen;
  logic       pick_ren;

  assign timeout = (cnt_q == CntLast);

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == StDone) last_d = owner_q;
  end

  // Resetting to M2 lets M1 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) last_q <= MstM2;
    else     last_q <= last_d;
  end
`endif

  bus_arbiter_arb_select u_arb_select (
    .req_i   ({m2_req, m1_req}),
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    .last_i  (last_q),
`endif
    .sel_o   (sel),
    .valid_o (sel_valid)
  );

  assign pick_wen = sel[1] ? m2_wen : m1_wen;
  assign pick_ren = sel[1] ? m2_ren : m1_ren;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sel_valid) state_d = StBusy;
      StBusy:  if (bus_ready || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    done_d      = done_q;
    err_d       = err_q;
    bus_addr_d  = bus_addr_q;
    bus_wen_d   = bus_wen_q;
    bus_ren_d   = bus_ren_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sel_valid) begin
          owner_d     = sel[1] ? MstM2 : MstM1;
          grant_d     = sel;
          bus_addr_d  = sel[1] ? m2_addr : m1_addr;
          bus_wdata_d = sel[1] ? m2_wdata : m1_wdata;
          bus_wen_d   = pick_wen;
          // A request with both strobes set is treated as a write.
          bus_ren_d   = pick_ren & ~pick_wen;
        end
      end
      StBusy: begin
        if (bus_ready) begin
          grant_d   = 2'b00;
          done_d    = mst_onehot(owner_q);
          err_d     = 2'b00;
          bus_wen_d = 1'b0;
          bus_ren_d = 1'b0;
          rdata_d   = bus_rdata;
          cnt_d     = '0;
        end else if (timeout) begin
          grant_d   = 2'b00;
          done_d    = mst_onehot(owner_q);
          err_d     = mst_onehot(owner_q);
          bus_wen_d = 1'b0;
          bus_ren_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        done_d = 2'b00;
        err_d  = 2'b00;
        cnt_d  = '0;
      end
      default: begin
        grant_d = 2'b00;
        done_d  = 2'b00;
        err_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      owner_q     <= MstM1;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      bus_addr_q  <= '0;
      bus_wen_q   <= 1'b0;
      bus_ren_q   <= 1'b0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wen_q   <= bus_wen_d;
      bus_ren_q   <= bus_ren_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign m1_grant  = grant_q[0];
  assign m2_grant  = grant_q[1];
  assign m1_done   = done_q[0];
  assign m2_done   = done_q[1];
  assign m1_err    = err_q[0];
  assign m2_err    = err_q[1];
  assign bus_addr  = bus_addr_q;
  assign bus_wen   = bus_wen_q;
  assign bus_ren   = bus_ren_q;
  assign bus_wdata = bus_wdata_q;
  assign m_rdata   = rdata_q;

endmodule
